expression_result_serializer: RTL and testbench

Receive-side companion to the packed expression-result bus. Accepts one 90-bit packed result vector (18 fields y0..y17, y0 in the MSBs) per valid/ready handshake, then emits the fields one per beat, extended to a common width, with field index and last flag. Sits between an expression block's packed output and the result checker/trace logger, decoupling the wide combinational result from a narrow sequential consumer.

---
 rtl/expression_result_serializer_pkg.sv | 23 ++
 rtl/expression_result_serializer_field_extend.sv | 38 +++
 rtl/expression_result_serializer.sv | 89 ++++++++
 tb/tb_expression_result_serializer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/expression_result_serializer_pkg.sv
// Shared constants, field geometry and state encoding for the packed
// expression-result serializer.
package expression_result_serializer_pkg;

  localparam int unsigned VEC_W    = 90;
  localparam int unsigned N_FIELDS = 18;
  localparam int unsigned IDX_W    = 5;
  localparam int unsigned RAW_W    = 6;

  // Bit k set => field k is two's-complement (sign-extended on output).
  localparam logic [N_FIELDS-1:0] SIGNED_MASK = 18'b111000111000111000;

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  // Fields repeat 4, 5, 6 bits wide in 15-bit groups.
  function automatic logic [2:0] field_width(input logic [IDX_W-1:0] idx);
    return 3'(32'd4 + (32'(idx) % 32'd3));
  endfunction

endpackage

// File: rtl/expression_result_serializer_field_extend.sv
// Widens the MSB-aligned top slice of the shift register to OUT_W bits,
// zero- or sign-extending according to the field's signedness.
module expression_result_serializer_field_extend
  import expression_result_serializer_pkg::*;
#(
  parameter int unsigned OUT_W = 8
) (
  input  logic [RAW_W-1:0] raw,
  input  logic [2:0]       width,
  input  logic             is_signed,
  output logic [OUT_W-1:0] val
);

  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;

  // The field occupies the top 'width' bits of raw.
  always_comb begin
    zext = '0;
    sext = '0;
    unique case (width)
      3'd4: begin
        zext = OUT_W'(raw[5:2]);
        sext = OUT_W'($signed(raw[5:2]));
      end
      3'd5: begin
        zext = OUT_W'(raw[5:1]);
        sext = OUT_W'($signed(raw[5:1]));
      end
      default: begin
        zext = OUT_W'(raw);
        sext = OUT_W'($signed(raw));
      end
    endcase
    val = is_signed ? sext : zext;
  end

endmodule

// File: rtl/expression_result_serializer.sv
// Accepts one 90-bit packed result vector per handshake and emits its 18
// fields one per beat, extended to OUT_W bits, with index and last flag.
module expression_result_serializer
  import expression_result_serializer_pkg::*;
#(
  parameter int unsigned OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VEC_W-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [OUT_W-1:0] out_val,
  output logic             out_last
);

  state_e           state_q, state_d;
  logic [VEC_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [2:0]       fw;
  logic             last;
  logic             fire;

  assign fw        = field_width(idx_q);
  assign last      = (idx_q == IDX_W'(N_FIELDS - 1));
  assign out_valid = (state_q == SEND);
  assign fire      = out_valid && out_ready;
  assign out_idx   = idx_q;
  assign out_last  = out_valid && last;
  // Combinational path from out_ready lets the next vector load with no bubble.
  assign in_ready  = rst_n && ((state_q == IDLE) || (fire && last));

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d = in_vec;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (fire) begin
          if (last) begin
            idx_d = '0;
            if (in_valid) begin
              shreg_d = in_vec;
            end else begin
              shreg_d = '0;
              state_d = IDLE;
            end
          end else begin
            shreg_d = shreg_q << fw;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
    end
  end

  expression_result_serializer_field_extend #(
    .OUT_W(OUT_W)
  ) u_field_extend (
    .raw      (shreg_q[VEC_W-1 -: RAW_W]),
    .width    (fw),
    .is_signed(SIGNED_MASK[idx_q]),
    .val      (out_val)
  );

endmodule

// File: tb/tb_expression_result_serializer.sv
// Table-driven bench: packed vectors with hand-computed per-field results,
// plus back-to-back, backpressure, in-flight poke and mid-vector reset.
module tb_expression_result_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [89:0] in_vec;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic [7:0]  out_val;
  logic        out_last;

  expression_result_serializer #(
    .OUT_W(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_vec   (in_vec),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_idx  (out_idx),
    .out_val  (out_val),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [89:0] vec;
    logic [7:0]  exp [18];
  } vec_t;

  vec_t tab [3];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Present a vector from IDLE; returns at the negedge where beat 0 should show.
  task automatic load(input int t);
    in_valid = 1'b1;
    in_vec   = tab[t].vec;
    out_ready = 1'b1;
    #1;
    check("load_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Walk beats of table entry t up to (not including) beat 'stop'.
  task automatic drain(input int t, input bit bp, input bit poke, input bit chain,
                       input int tnext, input int stop);
    int beat   = 0;
    int cycles = 0;
    bit fired;
    while (beat < stop && cycles < 200) begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (beat < 17) begin
        in_valid = poke;
        in_vec   = {3{30'h2AAA_5555}};
      end else begin
        in_valid = chain;
        in_vec   = tab[tnext].vec;
      end
      #1;
      check($sformatf("valid t%0d b%0d", t, beat), 32'(out_valid), 32'd1);
      check($sformatf("idx t%0d b%0d", t, beat), 32'(out_idx), 32'(beat));
      check($sformatf("val t%0d b%0d", t, beat), 32'(out_val), 32'(tab[t].exp[beat]));
      check($sformatf("last t%0d b%0d", t, beat), 32'(out_last), 32'(beat == 17));
      check($sformatf("in_ready t%0d b%0d", t, beat), 32'(in_ready),
            32'(out_ready && beat == 17));
      fired = out_ready;
      @(negedge clk);
      if (fired) beat++;
      cycles++;
    end
    if (cycles >= 200) check("drain_timeout", 32'(beat), 32'(stop));
    in_valid = 1'b0;
  endtask

  task automatic check_idle(input string name);
    out_ready = 1'b1;
    #1;
    check({name, "_out_valid"}, 32'(out_valid), 32'd0);
    check({name, "_out_last"}, 32'(out_last), 32'd0);
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    // Vector 0: y0=A, y3=1001 (signed), y5=100000 (signed)
    tab[0].vec = '0;
    tab[0].vec[89:86] = 4'hA;
    tab[0].vec[74:71] = 4'b1001;
    tab[0].vec[65:60] = 6'b100000;
    for (int k = 0; k < 18; k++) tab[0].exp[k] = 8'h00;
    tab[0].exp[0] = 8'h0A;
    tab[0].exp[3] = 8'hF9;
    tab[0].exp[5] = 8'hE0;
    // Vector 1: all ones
    tab[1].vec = '1;
    for (int g = 0; g < 6; g++) begin
      tab[1].exp[g*3+0] = (g % 2 == 0) ? 8'h0F : 8'hFF;
      tab[1].exp[g*3+1] = (g % 2 == 0) ? 8'h1F : 8'hFF;
      tab[1].exp[g*3+2] = (g % 2 == 0) ? 8'h3F : 8'hFF;
    end
    // Vector 2: mixed field values across groups
    tab[2].vec = '0;
    tab[2].vec[85:81] = 5'b10000;
    tab[2].vec[80:75] = 6'b111111;
    tab[2].vec[70:66] = 5'b10000;
    tab[2].vec[50:45] = 6'b000001;
    tab[2].vec[44:41] = 4'b0111;
    tab[2].vec[29:26] = 4'b1000;
    tab[2].vec[10:6]  = 5'b11111;
    tab[2].vec[5:0]   = 6'b011111;
    for (int k = 0; k < 18; k++) tab[2].exp[k] = 8'h00;
    tab[2].exp[1]  = 8'h10;
    tab[2].exp[2]  = 8'h3F;
    tab[2].exp[4]  = 8'hF0;
    tab[2].exp[8]  = 8'h01;
    tab[2].exp[9]  = 8'h07;
    tab[2].exp[12] = 8'h08;
    tab[2].exp[16] = 8'hFF;
    tab[2].exp[17] = 8'h1F;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_val", 32'(out_val), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_rst");

    load(0);
    drain(0, 1'b0, 1'b0, 1'b0, 0, 18);
    check_idle("after_v0");

    load(1);
    drain(1, 1'b0, 1'b0, 1'b1, 2, 18);
    drain(2, 1'b0, 1'b0, 1'b0, 0, 18);
    check_idle("after_b2b");

    load(2);
    drain(2, 1'b1, 1'b1, 1'b0, 0, 18);
    check_idle("after_bp");

    load(1);
    drain(1, 1'b0, 1'b0, 1'b0, 0, 9);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_idx", 32'(out_idx), 32'd0);
    check("midrst_out_val", 32'(out_val), 32'd0);
    check("midrst_out_last", 32'(out_last), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_idle("midrst_release");
    load(0);
    drain(0, 1'b0, 1'b0, 1'b0, 0, 18);
    check_idle("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
